// File: rtl/wb_pkg.sv
// Shared types and register constants for the MIPS writeback queue.
package wb_pkg;

   typedef enum logic [1:0] {
      DST_RT   = 2'd0,
      DST_RD   = 2'd1,
      DST_RA   = 2'd2,
      DST_NONE = 2'd3
   } dst_sel_e;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_MEM = 2'd1,
      SRC_PC4 = 2'd2
   } src_sel_e;

   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 31;

endpackage

// File: rtl/wb_sel.sv
// Writeback destination/source resolution: picks rt/rd/$ra and ALU/mem/PC+4,
// and flags whether the resolved write actually targets a real register.
module wb_sel
   import wb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [1:0]        dst_sel,
   input  logic [1:0]        src_sel,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] alu,
   input  logic [DATA_W-1:0] mem,
   input  logic [DATA_W-1:0] pc4,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              wr_vld
);

   dst_sel_e dst;
   src_sel_e src;

   always_comb begin
      dst    = dst_sel_e'(dst_sel);
      src    = src_sel_e'(src_sel);
      addr   = '0;
      data   = alu;
      wr_vld = 1'b0;

      case (dst)
         DST_RT:  addr = rt;
         DST_RD:  addr = rd;
         DST_RA:  addr = ADDR_W'(REG_RA);
         default: addr = '0;
      endcase

      // The reserved source encoding falls back to the ALU result.
      case (src)
         SRC_MEM: data = mem;
         SRC_PC4: data = pc4;
         default: data = alu;
      endcase

      wr_vld = (dst != DST_NONE) && (addr != ADDR_W'(REG_ZERO));
   end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue driving the register-file write port, with a pending-write
// scoreboard. Define WB_QUEUE_FWD_EN to add youngest-entry forwarding outputs.
module wb_queue
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_dst_sel,
   input  logic [1:0]               req_src_sel,
   input  logic [ADDR_W-1:0]        req_rt,
   input  logic [ADDR_W-1:0]        req_rd,
   input  logic [DATA_W-1:0]        req_alu,
   input  logic [DATA_W-1:0]        req_mem,
   input  logic [DATA_W-1:0]        req_pc4,
   input  logic                     flush,
   input  logic                     rf_grant,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_wadd,
   output logic [DATA_W-1:0]        rf_wdata,
   input  logic [ADDR_W-1:0]        chk_rs,
   input  logic [ADDR_W-1:0]        chk_rt,
   output logic                     rs_busy,
   output logic                     rt_busy,
`ifdef WB_QUEUE_FWD_EN
   output logic                     rs_fwd_hit,
   output logic                     rt_fwd_hit,
   output logic [DATA_W-1:0]        rs_fwd_data,
   output logic [DATA_W-1:0]        rt_fwd_data,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [ADDR_W-1:0] q_addr [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              sel_wv;

   logic              rs_match;
   logic              rt_match;
   logic [IDX_W-1:0]  idx;
`ifdef WB_QUEUE_FWD_EN
   logic [DATA_W-1:0] rs_young;
   logic [DATA_W-1:0] rt_young;
`endif

   wb_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_sel (
      .dst_sel (req_dst_sel),
      .src_sel (req_src_sel),
      .rt      (req_rt),
      .rd      (req_rd),
      .alu     (req_alu),
      .mem     (req_mem),
      .pc4     (req_pc4),
      .addr    (sel_addr),
      .data    (sel_data),
      .wr_vld  (sel_wv)
   );

   // Wrap bit distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                  (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
   assign count = wr_ptr - rd_ptr;

   assign req_ready = !full && !flush && !rst;
   assign push      = req_valid && req_ready && sel_wv;
   assign rf_we     = !empty && rf_grant && !flush && !rst;
   assign pop       = rf_we;

   assign rf_wadd  = (!empty && !rst) ? q_addr[rd_ptr[IDX_W-1:0]] : '0;
   assign rf_wdata = (!empty && !rst) ? q_data[rd_ptr[IDX_W-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Entry storage carries no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr[IDX_W-1:0]] <= sel_addr;
         q_data[wr_ptr[IDX_W-1:0]] <= sel_data;
      end
   end

   // Walk oldest to youngest so the last match seen is the youngest entry.
   always_comb begin
      rs_match = 1'b0;
      rt_match = 1'b0;
      idx      = '0;
`ifdef WB_QUEUE_FWD_EN
      rs_young = '0;
      rt_young = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr[IDX_W-1:0] + IDX_W'(k);
         if (PTR_W'(k) < count) begin
            if (q_addr[idx] == chk_rs) begin
               rs_match = 1'b1;
`ifdef WB_QUEUE_FWD_EN
               rs_young = q_data[idx];
`endif
            end
            if (q_addr[idx] == chk_rt) begin
               rt_match = 1'b1;
`ifdef WB_QUEUE_FWD_EN
               rt_young = q_data[idx];
`endif
            end
         end
      end
   end

   assign rs_busy = rs_match && (chk_rs != ADDR_W'(REG_ZERO)) && !rst;
   assign rt_busy = rt_match && (chk_rt != ADDR_W'(REG_ZERO)) && !rst;

`ifdef WB_QUEUE_FWD_EN
   assign rs_fwd_hit  = rs_busy;
   assign rt_fwd_hit  = rt_busy;
   assign rs_fwd_data = rs_busy ? rs_young : '0;
   assign rt_fwd_data = rt_busy ? rt_young : '0;
`endif

endmodule
